// File: rtl/pwm_multi_ch_if.sv
// Duty-write bus between the duty-write controller and the PWM engine.
// upd_pending reports that a written shadow duty has not yet taken effect.
interface pwm_multi_ch_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_duty;
  logic             upd_pending;

  modport master (
    output wr_en,
    output wr_ch,
    output wr_duty,
    input  upd_pending
  );

  modport slave (
    input  wr_en,
    input  wr_ch,
    input  wr_duty,
    output upd_pending
  );
endinterface

// File: rtl/pwm_multi_ch.sv
// N-channel PWM engine: shared prescaled counter (edge or center aligned), double-buffered
// duty/period/mode that switch only at a period boundary, per-channel output polarity.
module pwm_multi_ch #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   period_in,
  input  logic               center_in,
  pwm_multi_ch_if.slave      duty_if,
  input  logic [NCH-1:0]     polarity,
  output logic [NCH-1:0]     pwm_out,
  output logic [WIDTH-1:0]   count,
  output logic               period_tick
);
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0]   count_q, count_d;
  dir_e               dir_q, dir_d;
  logic [WIDTH-1:0]   shadow_q [NCH];
  logic [WIDTH-1:0]   shadow_d [NCH];
  logic [WIDTH-1:0]   active_q [NCH];
  logic [WIDTH-1:0]   active_d [NCH];
  logic [WIDTH-1:0]   period_q, period_d;
  logic               mode_q, mode_d;
  logic [NCH-1:0]     pwm_q, pwm_d;
  logic               tick_q;
  logic               upd_q, upd_d;
  logic               tick, boundary, load, wr_ok;

  // Prescaler and counter / direction state machine.
  always_comb begin
    tick        = en && (presc_cnt_q == presc);
    presc_cnt_d = presc_cnt_q;
    if (tick) begin
      presc_cnt_d = '0;
    end else if (en) begin
      presc_cnt_d = presc_cnt_q + 1'b1;
    end

    count_d  = count_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (tick) begin
      if (!mode_q) begin
        if (count_q >= period_q) begin
          count_d  = '0;
          boundary = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else if (dir_q == DirUp) begin
        if (count_q >= period_q) begin
          // A period of 0 or 1 has no room to turn around, so it wraps like edge mode.
          if (period_q <= WIDTH'(1)) begin
            count_d  = '0;
            boundary = 1'b1;
          end else begin
            count_d = period_q - 1'b1;
            dir_d   = DirDown;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q <= WIDTH'(1)) begin
          count_d  = '0;
          dir_d    = DirUp;
          boundary = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // Shadow/active double buffering and output compare.
  always_comb begin
    wr_ok    = duty_if.wr_en && (32'(duty_if.wr_ch) < NCH);
    load     = boundary || !en;
    shadow_d = shadow_q;
    active_d = active_q;
    period_d = period_q;
    mode_d   = mode_q;
    upd_d    = upd_q;
    pwm_d    = '0;

    if (load) begin
      active_d = shadow_q;
      period_d = period_in;
      mode_d   = center_in;
      upd_d    = 1'b0;
    end
    if (wr_ok) begin
      upd_d = 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (wr_ok && (duty_if.wr_ch == CH_W'(i))) begin
        shadow_d[i] = duty_if.wr_duty;
      end
      pwm_d[i] = en ? ((count_q < active_q[i]) ^ polarity[i]) : polarity[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
      count_q     <= '0;
      dir_q       <= DirUp;
      period_q    <= '0;
      mode_q      <= 1'b0;
      pwm_q       <= '0;
      tick_q      <= 1'b0;
      upd_q       <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      period_q    <= period_d;
      mode_q      <= mode_d;
      pwm_q       <= pwm_d;
      tick_q      <= boundary;
      upd_q       <= upd_d;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_out             = pwm_q;
  assign count               = count_q;
  assign period_tick         = tick_q;
  assign duty_if.upd_pending = upd_q;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: a 4-channel and a 3-channel instance sharing clock,
// reset and counter settings, each with its own duty-write bus.
module tb_pwm_multi_ch;
  logic       clk, rst, en, center_in;
  logic [7:0] presc, period_in;
  logic [3:0] polarity, pwm_out;
  logic [7:0] count;
  logic       period_tick;
  logic [2:0] polarity3, pwm_out3;
  logic [7:0] count3;
  logic       period_tick3;
  int         checks, errors;
  logic       exp_b;
  logic [7:0] exp_c;

  pwm_multi_ch_if #(.NCH(4), .WIDTH(8)) bus ();
  pwm_multi_ch_if #(.NCH(3), .WIDTH(8)) bus3 ();

  pwm_multi_ch #(.NCH(4), .WIDTH(8), .PRESC_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .presc(presc), .period_in(period_in),
    .center_in(center_in), .duty_if(bus), .polarity(polarity), .pwm_out(pwm_out),
    .count(count), .period_tick(period_tick)
  );

  pwm_multi_ch #(.NCH(3), .WIDTH(8), .PRESC_W(8)) dut3 (
    .clk(clk), .rst(rst), .en(en), .presc(presc), .period_in(period_in),
    .center_in(center_in), .duty_if(bus3), .polarity(polarity3), .pwm_out(pwm_out3),
    .count(count3), .period_tick(period_tick3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    bus.wr_en = 1'b0;
    bus3.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d);
    bus.wr_ch = ch;
    bus.wr_duty = d;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; presc = 8'd0; period_in = 8'd0; center_in = 1'b0;
    polarity = 4'b0; polarity3 = 3'b0;
    bus.wr_en = 1'b0; bus.wr_ch = 2'd0; bus.wr_duty = 8'd0;
    bus3.wr_en = 1'b0; bus3.wr_ch = 2'd0; bus3.wr_duty = 8'd0;
    #1;
    checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0000", pwm_out); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", period_tick); end
    checks++; if (bus.upd_pending !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b want 0", bus.upd_pending); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_idle_count: got %0d want 0", count); end
  endtask

  task automatic test_edge_basic();
    do_reset();
    presc = 8'd0; period_in = 8'd9; center_in = 1'b0; polarity = 4'b0;
    wr(2'd0, 8'd3);
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      exp_c = 8'((i + 1) % 10);
      checks++; if (count !== exp_c) begin errors++; $display("FAIL edge_count[%0d]: got %0d want %0d", i, count, exp_c); end
      exp_b = ((i + 1) % 10 == 0);
      checks++; if (period_tick !== exp_b) begin errors++; $display("FAIL edge_tick[%0d]: got %b want %b", i, period_tick, exp_b); end
      exp_b = (i % 10 < 3);
      checks++; if (pwm_out[0] !== exp_b) begin errors++; $display("FAIL edge_pwm0[%0d]: got %b want %b", i, pwm_out[0], exp_b); end
    end
  endtask

  task automatic test_prescaler();
    do_reset();
    presc = 8'd3; period_in = 8'd9; center_in = 1'b0;
    wr(2'd0, 8'd3);
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      exp_c = 8'(((i + 1) / 4) % 10);
      checks++; if (count !== exp_c) begin errors++; $display("FAIL presc_count[%0d]: got %0d want %0d", i, count, exp_c); end
      exp_b = ((i + 1) % 40 == 0);
      checks++; if (period_tick !== exp_b) begin errors++; $display("FAIL presc_tick[%0d]: got %b want %b", i, period_tick, exp_b); end
      exp_b = (i % 40 < 12);
      checks++; if (pwm_out[0] !== exp_b) begin errors++; $display("FAIL presc_pwm0[%0d]: got %b want %b", i, pwm_out[0], exp_b); end
    end
    presc = 8'd0;
  endtask

  task automatic test_duty_update();
    do_reset();
    presc = 8'd0; period_in = 8'd9; center_in = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      exp_b = (i >= 4 && i <= 8);
      checks++; if (bus.upd_pending !== exp_b) begin errors++; $display("FAIL upd_pending[%0d]: got %b want %b", i, bus.upd_pending, exp_b); end
      exp_b = (i >= 10 && i % 10 < 5);
      checks++; if (pwm_out[1] !== exp_b) begin errors++; $display("FAIL upd_pwm1[%0d]: got %b want %b", i, pwm_out[1], exp_b); end
      if (i == 3) begin
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL upd_count_at_write: got %0d want 4", count); end
        bus.wr_ch = 2'd1; bus.wr_duty = 8'd5; bus.wr_en = 1'b1;
      end else begin
        bus.wr_en = 1'b0;
      end
    end
  endtask

  task automatic test_center();
    logic [7:0] seq [8];
    seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1};
    do_reset();
    presc = 8'd0; period_in = 8'd4; center_in = 1'b1;
    wr(2'd2, 8'd2);
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp_c = seq[(i + 1) % 8];
      checks++; if (count !== exp_c) begin errors++; $display("FAIL center_count[%0d]: got %0d want %0d", i, count, exp_c); end
      exp_b = (seq[i % 8] < 8'd2);
      checks++; if (pwm_out[2] !== exp_b) begin errors++; $display("FAIL center_pwm2[%0d]: got %b want %b", i, pwm_out[2], exp_b); end
      exp_b = ((i + 1) % 8 == 0);
      checks++; if (period_tick !== exp_b) begin errors++; $display("FAIL center_tick[%0d]: got %b want %b", i, period_tick, exp_b); end
    end
    center_in = 1'b0;
  endtask

  task automatic test_boundaries();
    do_reset();
    presc = 8'd0; period_in = 8'd9; center_in = 1'b0; polarity = 4'b1000;
    wr(2'd1, 8'd10);
    wr(2'd2, 8'd2);
    @(negedge clk);
    checks++; if (pwm_out !== 4'b1000) begin errors++; $display("FAIL bnd_idle_pwm: got %b want 1000", pwm_out); end
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++; if (pwm_out[0] !== 1'b0) begin errors++; $display("FAIL bnd_duty0[%0d]: got %b want 0", i, pwm_out[0]); end
      checks++; if (pwm_out[1] !== 1'b1) begin errors++; $display("FAIL bnd_duty10[%0d]: got %b want 1", i, pwm_out[1]); end
      checks++; if (pwm_out[3] !== 1'b1) begin errors++; $display("FAIL bnd_pol3[%0d]: got %b want 1", i, pwm_out[3]); end
      if (i < 10) exp_b = (i % 10 < 2);
      else if (i < 20) exp_b = (i % 10 < 7);
      else exp_b = (i % 10 < 4);
      checks++; if (pwm_out[2] !== exp_b) begin errors++; $display("FAIL bnd_coinc_pwm2[%0d]: got %b want %b", i, pwm_out[2], exp_b); end
      exp_b = (i >= 2 && i <= 18);
      checks++; if (bus.upd_pending !== exp_b) begin errors++; $display("FAIL bnd_coinc_upd[%0d]: got %b want %b", i, bus.upd_pending, exp_b); end
      if (i == 1 || i == 8) begin
        bus.wr_ch = 2'd2; bus.wr_duty = (i == 1) ? 8'd7 : 8'd4; bus.wr_en = 1'b1;
      end else begin
        bus.wr_en = 1'b0;
      end
    end
    polarity = 4'b0;
  endtask

  task automatic test_en_hold();
    do_reset();
    presc = 8'd0; period_in = 8'd9; center_in = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (count !== 8'd5) begin errors++; $display("FAIL hold_pre_count: got %0d want 5", count); end
    en = 1'b0;
    period_in = 8'd6;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (count !== 8'd5) begin errors++; $display("FAIL hold_count[%0d]: got %0d want 5", i, count); end
      checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL hold_tick[%0d]: got %b want 0", i, period_tick); end
    end
    en = 1'b1;
    @(negedge clk);
    checks++; if (count !== 8'd6) begin errors++; $display("FAIL resume_count0: got %0d want 6", count); end
    @(negedge clk);
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL resume_wrap_count: got %0d want 0", count); end
    checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL resume_wrap_tick: got %b want 1", period_tick); end
  endtask

  task automatic test_small_instance();
    do_reset();
    presc = 8'd0; period_in = 8'd9; center_in = 1'b0; polarity3 = 3'b0;
    bus3.wr_ch = 2'd3; bus3.wr_duty = 8'd5; bus3.wr_en = 1'b1;
    @(negedge clk);
    bus3.wr_en = 1'b0;
    checks++; if (bus3.upd_pending !== 1'b0) begin errors++; $display("FAIL oob_upd: got %b want 0", bus3.upd_pending); end
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (pwm_out3 !== 3'b000) begin errors++; $display("FAIL oob_pwm[%0d]: got %b want 000", i, pwm_out3); end
      checks++; if (bus3.upd_pending !== 1'b0) begin errors++; $display("FAIL oob_upd_run[%0d]: got %b want 0", i, bus3.upd_pending); end
    end
    do_reset();
    bus3.wr_ch = 2'd0; bus3.wr_duty = 8'd5; bus3.wr_en = 1'b1;
    @(negedge clk);
    bus3.wr_en = 1'b0;
    checks++; if (bus3.upd_pending !== 1'b1) begin errors++; $display("FAIL small_wr_upd: got %b want 1", bus3.upd_pending); end
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus3.wr_ch = 2'd1; bus3.wr_duty = 8'd7; bus3.wr_en = 1'b1;
    @(negedge clk);
    bus3.wr_en = 1'b0;
    checks++; if (count3 !== 8'd3) begin errors++; $display("FAIL small_pre_count: got %0d want 3", count3); end
    checks++; if (pwm_out3 !== 3'b001) begin errors++; $display("FAIL small_pre_pwm: got %b want 001", pwm_out3); end
    checks++; if (bus3.upd_pending !== 1'b1) begin errors++; $display("FAIL small_pre_upd: got %b want 1", bus3.upd_pending); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pwm_out3 !== 3'b000) begin errors++; $display("FAIL midrst_pwm: got %b want 000", pwm_out3); end
    checks++; if (count3 !== 8'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count3); end
    checks++; if (period_tick3 !== 1'b0) begin errors++; $display("FAIL midrst_tick: got %b want 0", period_tick3); end
    checks++; if (bus3.upd_pending !== 1'b0) begin errors++; $display("FAIL midrst_upd: got %b want 0", bus3.upd_pending); end
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    polarity3 = 3'b101;
    polarity = 4'b0110;
    @(negedge clk);
    checks++; if (pwm_out3 !== 3'b101) begin errors++; $display("FAIL dis_pol3: got %b want 101", pwm_out3); end
    checks++; if (pwm_out !== 4'b0110) begin errors++; $display("FAIL dis_pol4: got %b want 0110", pwm_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_edge_basic();
    test_prescaler();
    test_duty_update();
    test_center();
    test_boundaries();
    test_en_hold();
    test_small_instance();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Parametrised N-channel PWM engine, next generation of the fixed 3-channel 8-bit PWM path. It has one shared counter with:
- a programmable prescaler and programmable period,
- edge-aligned or center-aligned counting,
- per-channel output polarity.
Duty, period and mode are double-buffered: software writes land in shadow registers and take effect only at a period boundary, so a PWM cycle never glitches. The block sits between the duty-write controller and the PWM output pins.

Parameters:
NCH, 4, number of PWM channels (1..16)
WIDTH, 8, counter/duty/period width in bits (4..16)
PRESC_W, 8, prescaler reload width in bits
CH_W, $clog2(NCH) min 1, channel-select width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  run enable
presc  in  PRESC_W  prescaler reload; counter advances once per presc+1 clks
period_in  in  WIDTH  shadow period value P
center_in  in  1  shadow mode: 0 edge-aligned, 1 center-aligned
wr_en  in  1  single-clk duty write strobe
wr_ch  in  CH_W  channel for duty write
wr_duty  in  WIDTH  duty value to write
polarity  in  NCH  per-channel invert, applied combinationally before the output register
pwm_out  out  NCH  registered PWM outputs
count  out  WIDTH  current counter value
period_tick  out  1  1-clk pulse on period boundary
upd_pending  out  1  shadow duty written but not yet applied

Behaviour:
- Reset values are 0 for all of: prescaler count, count, dir (up), shadow duty[], active duty[], active period, active mode, pwm_out, period_tick, upd_pending.
- Prescaler and tick:
  - tick = en & (presc_cnt == presc).
  - On a tick, presc_cnt goes to 0; otherwise, when en=1, presc_cnt increments.
  - presc=0 gives a tick on every clk.
  - If presc is lowered below presc_cnt, presc_cnt keeps incrementing, wraps through 2^PRESC_W, then matches. This is accepted.
- Edge mode (active mode 0), on each tick:
  - count==P or count>P → count←0 and boundary.
  - Otherwise count←count+1.
  - Period is P+1 ticks.
- Center mode (active mode 1), on each tick:
  - dir up and count≥P: if P≤1, count←0, stay up, boundary; else count←P-1, dir←down.
  - dir up and count<P: count+1.
  - dir down and count≤1: count←0, dir←up, boundary.
  - dir down and count>1: count-1.
  - P=4 sequence is 0,1,2,3,4,3,2,1, repeating (period 2P ticks).
- Boundary actions, all in the same clk:
  - active duty[] ← shadow duty[]; active period ← period_in; active mode ← center_in; dir←up.
  - period_tick=1; upd_pending←0.
  - period_in and center_in are sampled only at a boundary, or while en=0.
- Duty write:
  - wr_en with wr_ch<NCH sets shadow[wr_ch]←wr_duty and upd_pending←1.
  - wr_en with wr_ch≥NCH is ignored entirely.
  - Write and boundary in the same clk: active takes the old shadow value, shadow takes the new value, and upd_pending stays 1.
- Output, every clk, 1 clk after count:
  - pwm_out[i] ← (count < active_duty[i]) ^ polarity[i] when en=1.
  - pwm_out[i] ← polarity[i] (inactive level) when en=0.
  - duty=0 means always inactive.
  - In edge mode, duty≥P+1 means always active.
- en=0:
  - Counter, dir and prescaler hold; no ticks; period_tick=0.
  - Active registers load from shadow/period_in/center_in every clk; upd_pending←0 unless a write occurs in the same clk.
  - Writes are still accepted.
  - On en rising, counting resumes from the held count with the fresh settings.
- Reset mid-operation: all state returns to reset values immediately (async).
- Width rules: count, duty and P are unsigned WIDTH bits, with no overflow beyond 2^WIDTH-1. With P=2^WIDTH-1 in edge mode, duty=2^WIDTH-1 is high 255/256 ticks at WIDTH=8.

Test Plan:
- Reset, then en=1, presc=0, P=9, edge, duty0=3 (written while en=0) → pwm0 high 3 clks of every 10, period_tick every 10 clks, count sequence 0..9.
- presc=3 with same settings → count advances every 4 clks; period_tick every 40 clks; pwm0 high 12 clks per period.
- Running P=9; at count=4 write ch1=5 → upd_pending=1; pwm1 unchanged until period_tick; from next period pwm1 high 5/10; upd_pending=0.
- Center mode, P=4, duty2=2 → count 0,1,2,3,4,3,2,1 repeating; pwm2 high on counts 0,1,1 (3 of 8 ticks); period_tick on each entry to 0.
- Boundaries at P=9:
  - duty=0 → always low.
  - duty=10 → always high.
  - polarity[3]=1 with duty3=0 → pwm3 constantly high.
  - Write coincident with boundary → old shadow applied, new value next period.
- NCH=3 instance: wr_ch=3 write → no state change, upd_pending stays 0. Assert rst mid-period → all outputs 0 same cycle; en=0 forces pwm_out=polarity.
